// File: rtl/usr_shift_core_if.sv
// Handshake/data bundle between the USR mode-select front end and the register stage.
// `USR_SERIAL_IN_EN adds the SerIn fill bit used by the logical shifts.
interface usr_shift_core_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 3
);
    logic             Start;
    logic [2:0]       Mode;
    logic [CNTW-1:0]  Amount;
    logic [WIDTH-1:0] D;
`ifdef USR_SERIAL_IN_EN
    logic             SerIn;
`endif
    logic [WIDTH-1:0] Q;
    logic             Busy;
    logic             Done;
    logic             Ovf;

    modport master (
        output Start, Mode, Amount, D,
`ifdef USR_SERIAL_IN_EN
        output SerIn,
`endif
        input  Q, Busy, Done, Ovf
    );

    modport slave (
        input  Start, Mode, Amount, D,
`ifdef USR_SERIAL_IN_EN
        input  SerIn,
`endif
        output Q, Busy, Done, Ovf
    );
endinterface

// File: rtl/usr_shift_core.sv
// Universal shift register stage: hold, rotate/logical/arithmetic shifts, load.
// Optional macro USR_SERIAL_IN_EN: logical shifts take their fill bit from SerIn.
module usr_shift_core #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 3
) (
    input logic           Clock,
    input logic           Resetn,
    usr_shift_core_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_CSR  = 3'b001;
    localparam logic [2:0] M_CSL  = 3'b010;
    localparam logic [2:0] M_LSR  = 3'b011;
    localparam logic [2:0] M_LSL  = 3'b100;
    localparam logic [2:0] M_ASR  = 3'b101;
    localparam logic [2:0] M_ASL  = 3'b110;
    localparam logic [2:0] M_LOAD = 3'b111;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_q, w_q_nx, w_step;
    logic [CNTW-1:0]  r_cnt, w_cnt_nx;
    logic [2:0]       r_mode, w_mode_nx;
    logic             r_done, w_done_nx;
    logic             r_ovf, w_ovf_nx;
    logic             w_step_ovf;
    logic             w_fill;

`ifdef USR_SERIAL_IN_EN
    assign w_fill = bus.SerIn;
`else
    assign w_fill = 1'b0;
`endif

    // One single-bit shift of the current register under the latched mode
    always_comb begin
        w_step     = r_q;
        w_step_ovf = 1'b0;
        case (r_mode)
            M_CSR: w_step = {r_q[0], r_q[WIDTH-1:1]};
            M_CSL: w_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            M_LSR: w_step = {w_fill, r_q[WIDTH-1:1]};
            M_LSL: w_step = {r_q[WIDTH-2:0], w_fill};
            M_ASR: w_step = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            M_ASL: begin
                w_step     = {r_q[WIDTH-2:0], 1'b0};
                w_step_ovf = r_q[WIDTH-1] ^ r_q[WIDTH-2];
            end
            default: w_step = r_q;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_q_nx     = r_q;
        w_cnt_nx   = r_cnt;
        w_mode_nx  = r_mode;
        w_ovf_nx   = r_ovf;
        w_done_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Start) begin
                    w_ovf_nx = 1'b0;
                    if (bus.Mode == M_LOAD) begin
                        w_q_nx    = bus.D;
                        w_done_nx = 1'b1;
                    end else if (bus.Mode == M_HOLD || bus.Amount == '0) begin
                        w_done_nx = 1'b1;
                    end else begin
                        w_mode_nx  = bus.Mode;
                        w_cnt_nx   = bus.Amount;
                        w_state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_q_nx   = w_step;
                w_ovf_nx = r_ovf | w_step_ovf;
                w_cnt_nx = r_cnt - CNTW'(1);
                if (r_cnt == CNTW'(1)) begin
                    w_state_nx = IDLE;
                    w_done_nx  = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_mode  <= M_HOLD;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_q     <= w_q_nx;
            r_cnt   <= w_cnt_nx;
            r_mode  <= w_mode_nx;
            r_done  <= w_done_nx;
            r_ovf   <= w_ovf_nx;
        end
    end

    assign bus.Q    = r_q;
    assign bus.Busy = (r_state == SHIFT);
    assign bus.Done = r_done;
    assign bus.Ovf  = r_ovf;
endmodule

// File: tb/tb_usr_shift_core.sv
// Self-checking bench for usr_shift_core: directed scenarios plus a
// randomized operation stream checked against a whole-operation model.
module tb_usr_shift_core;
    localparam int W  = 8;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    usr_shift_core_if #(.WIDTH(W), .CNTW(CW)) bus ();

    usr_shift_core #(.WIDTH(W), .CNTW(CW)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus)
    );

    // Result of a whole operation: {ovf, q} after n single-bit shifts
    function automatic logic [W:0] model(input logic [W-1:0] q,
                                         input logic [2:0] m, input int n);
        logic [2*W-1:0] qq;
        logic [W-1:0]   r;
        logic           o;
        qq = {q, q};
        r  = q;
        o  = 1'b0;
        case (m)
            3'd1: begin qq = qq >> n; r = qq[W-1:0]; end
            3'd2: begin qq = qq << n; r = qq[2*W-1:W]; end
            3'd3: r = q >> n;
            3'd4: r = q << n;
            3'd5: r = W'($signed(q) >>> n);
            3'd6: begin
                r = q << n;
                o = (W'($signed(r) >>> n) != q);
            end
            default: r = q;
        endcase
        return {o, r};
    endfunction

    task automatic issue(input logic [2:0] m, input logic [CW-1:0] a,
                         input logic [W-1:0] d);
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.Mode   = m;
        bus.Amount = a;
        bus.D      = d;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.Q !== 8'h00 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: Q=%h B=%b D=%b O=%b want 00 0 0 0", bus.Q, bus.Busy, bus.Done, bus.Ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'b111, 3'd0, 8'hFF);
        n_cmp++;
        if (bus.Q !== 8'hFF) begin
            n_err++;
            $display("FAIL reset_preload: Q=%h want ff", bus.Q);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.Q !== 8'h00 || bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ff: Q=%h B=%b D=%b O=%b want 00 0 0 0", bus.Q, bus.Busy, bus.Done, bus.Ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        issue(3'b111, 3'd5, 8'hB4);
        n_cmp++;
        if (bus.Q !== 8'hB4 || bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL load: Q=%h D=%b B=%b want b4 1 0", bus.Q, bus.Done, bus.Busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.Q !== 8'hB4 || bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL load_after: Q=%h D=%b B=%b want b4 0 0", bus.Q, bus.Done, bus.Busy);
        end
    endtask

    task automatic test_shift_trace(input string nm, input logic [2:0] m,
                                    input logic [CW-1:0] a, input logic [W-1:0] q0);
        logic [W:0] e;
        issue(3'b111, 3'd0, q0);
        issue(m, a, 8'h00);
        n_cmp++;
        if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || bus.Q !== q0) begin
            n_err++;
            $display("FAIL %s_accept: B=%b D=%b Q=%h want 1 0 %h", nm, bus.Busy, bus.Done, bus.Q, q0);
        end
        for (int i = 1; i <= int'(a); i++) begin
            @(posedge clk);
            #1;
            e = model(q0, m, i);
            n_cmp++;
            if (bus.Q !== e[W-1:0] || bus.Ovf !== e[W]) begin
                n_err++;
                $display("FAIL %s_step%0d: Q=%h O=%b want %h %b", nm, i, bus.Q, bus.Ovf, e[W-1:0], e[W]);
            end
            n_cmp++;
            if (bus.Busy !== (i < int'(a)) || bus.Done !== (i == int'(a))) begin
                n_err++;
                $display("FAIL %s_hs%0d: B=%b D=%b want %b %b", nm, i, bus.Busy, bus.Done,
                         i < int'(a), i == int'(a));
            end
        end
        @(posedge clk);
        #1;
        e = model(q0, m, int'(a));
        n_cmp++;
        if (bus.Done !== 1'b0 || bus.Q !== e[W-1:0]) begin
            n_err++;
            $display("FAIL %s_end: D=%b Q=%h want 0 %h", nm, bus.Done, bus.Q, e[W-1:0]);
        end
    endtask

    task automatic test_asl_sticky();
        test_shift_trace("asl", 3'b110, 3'd2, 8'h30);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.Ovf !== 1'b1 || bus.Q !== 8'hC0) begin
            n_err++;
            $display("FAIL asl_sticky: O=%b Q=%h want 1 c0", bus.Ovf, bus.Q);
        end
        issue(3'b000, 3'd3, 8'h00);
        n_cmp++;
        if (bus.Ovf !== 1'b0 || bus.Done !== 1'b1 || bus.Q !== 8'hC0) begin
            n_err++;
            $display("FAIL asl_clear: O=%b D=%b Q=%h want 0 1 c0", bus.Ovf, bus.Done, bus.Q);
        end
    endtask

    task automatic test_interference();
        logic bad;
        issue(3'b111, 3'd0, 8'hFF);
        issue(3'b100, 3'd5, 8'h00);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Mode  = 3'b111;
        bus.D     = 8'h00;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        n_cmp++;
        if (bus.Q !== 8'hFE || bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
            n_err++;
            $display("FAIL intf_ignore: Q=%h B=%b D=%b want fe 1 0", bus.Q, bus.Busy, bus.Done);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.Q !== 8'hFC) begin
            n_err++;
            $display("FAIL intf_shift2: Q=%h want fc", bus.Q);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++;
        if (bus.Q !== 8'h00 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            n_err++;
            $display("FAIL intf_reset: Q=%h B=%b D=%b want 00 0 0", bus.Q, bus.Busy, bus.Done);
        end
        bad = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
            if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.Q !== 8'h00) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL intf_no_done: spurious activity=%b want 0", bad);
        end
    endtask

    // Back-to-back random ops; each new Start lands in the previous Done cycle
    task automatic test_random();
        logic [W-1:0]  q;
        logic [W:0]    e;
        logic [2:0]    m;
        logic [CW-1:0] a;
        logic [W-1:0]  d;
        int            lat, want_lat;
        q = bus.Q;
        for (int k = 0; k < 80; k++) begin
            m = 3'($urandom_range(0, 7));
            a = CW'($urandom);
            d = W'($urandom);
            if (m == 3'b111) e = {1'b0, d};
            else e = model(q, m, int'(a));
            want_lat = (m != 3'b000 && m != 3'b111 && a != 0) ? int'(a) + 1 : 1;
            issue(m, a, d);
            lat = 1;
            while (bus.Done !== 1'b1 && lat < 20) begin
                if (bus.Busy === 1'b1) begin
                    @(negedge clk);
                    bus.Start  = 1'($urandom_range(0, 1));
                    bus.Mode   = 3'($urandom);
                    bus.Amount = CW'($urandom);
                    bus.D      = W'($urandom);
                end
                @(posedge clk);
                #1;
                bus.Start = 1'b0;
                lat++;
            end
            n_cmp++;
            if (bus.Done !== 1'b1 || lat != want_lat) begin
                n_err++;
                $display("FAIL rand%0d_lat: m=%0d a=%0d done=%b lat=%0d want %0d",
                         k, m, a, bus.Done, lat, want_lat);
            end
            n_cmp++;
            if (bus.Q !== e[W-1:0] || bus.Ovf !== e[W] || bus.Busy !== 1'b0) begin
                n_err++;
                $display("FAIL rand%0d_res: m=%0d a=%0d Q=%h O=%b B=%b want %h %b 0",
                         k, m, a, bus.Q, bus.Ovf, bus.Busy, e[W-1:0], e[W]);
            end
            q = e[W-1:0];
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.Done !== 1'b0 || bus.Q !== q) begin
            n_err++;
            $display("FAIL rand_tail: D=%b Q=%h want 0 %h", bus.Done, bus.Q, q);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.Start  = 1'b0;
        bus.Mode   = 3'b000;
        bus.Amount = '0;
        bus.D      = '0;
`ifdef USR_SERIAL_IN_EN
        bus.SerIn  = 1'b0;
`endif
        test_reset();
        test_load();
        test_shift_trace("csr", 3'b001, 3'd3, 8'hB4);
        test_shift_trace("asr", 3'b101, 3'd2, 8'h96);
        test_asl_sticky();
        test_shift_trace("csl_max", 3'b010, 3'd7, 8'h81);
        test_shift_trace("lsl", 3'b100, 3'd4, 8'hA7);
        test_shift_trace("lsr", 3'b011, 3'd7, 8'hC3);
        test_interference();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/usr_shift_core.md
Name: usr_shift_core

Overview:
- Sequential register stage of the universal shift register (USR); sits directly downstream of the 8-to-1 per-bit mode-select multiplexers.
- Holds the WIDTH-bit register. Executes one operation per Start: hold, circular/logical/arithmetic shifts, or parallel load.
- A shift operation repeats for Amount cycles, using a Busy/Done handshake.
- Mode encoding is identical to the mux select encoding, so the mode field can drive the per-bit select lines directly.

Parameters:
- WIDTH, 8, register width in bits.
- CNTW, 3, width of Amount; maximum shift count is 2^CNTW-1.

Ports:
- Clock  input  1  rising-edge clock.
- Resetn  input  1  synchronous, active-low reset.
- Start  input  1  request a new operation; sampled only when Busy=0.
- Mode  input  3  operation code: 000 hold, 001 circular shift right, 010 circular shift left, 011 logical shift right, 100 logical shift left, 101 arithmetic shift right, 110 arithmetic shift left, 111 load.
- Amount  input  CNTW  number of single-bit shifts; ignored for hold and load.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents.
- Busy  output  1  high while a multi-cycle shift is in progress.
- Done  output  1  one-cycle pulse when an operation completes.
- Ovf  output  1  arithmetic-shift-left overflow flag.

Behaviour:
- Reset:
  - Resetn=0 at a rising edge forces Q=0, Busy=0, Done=0, Ovf=0, internal count=0, latched mode=000.
  - Reset has priority over every other input and aborts any operation in progress; no Done pulse follows.
- FSM states: IDLE, SHIFT.
  - Busy=1 exactly when the FSM is in SHIFT.
  - Done is registered and is 0 in every cycle except the completion pulse.
- IDLE, Start=1 at edge k:
  - Ovf<=0.
  - Load (111): Q<=D; Done=1 for the cycle after k; remain in IDLE.
  - Hold (000), or Amount=0 with any shift mode: Q unchanged; Done=1 for the cycle after k; remain in IDLE.
  - Otherwise: latch Mode and Amount; go to SHIFT (Busy=1 after edge k).
- SHIFT:
  - One single-bit shift per edge, on edges k+1 through k+N, where N = latched Amount.
  - At edge k+N: go to IDLE, Busy<=0, Done<=1 for one cycle.
  - Total latency from Start to Done: N+1 edges.
- Single-bit shift rules:
  - Circular right: LSB moves to MSB. Circular left: MSB moves to LSB.
  - Logical right: 0 enters at MSB. Logical left: 0 enters at LSB.
  - Arithmetic right: MSB is replicated.
  - Arithmetic left: 0 enters at LSB. If the new MSB differs from the old MSB, Ovf<=1. Ovf is sticky until the next accepted Start.
- Start while Busy=1 is ignored; no queuing.
- Mode, Amount and D changing during SHIFT have no effect.
- Start and Done coincident in the same cycle (Done high, FSM already IDLE): Start is accepted normally.
- Amount = 2^CNTW-1 is legal; circular shifts by WIDTH return the original value.
- Q updates only on the edges listed above; otherwise it holds.

Optional Feature:
- Macro: USR_SERIAL_IN_EN.
- Defined:
  - Adds input SerIn (1 bit).
  - Logical shift right inserts SerIn at the MSB; logical shift left inserts SerIn at the LSB.
  - SerIn is sampled at every shift edge.
- Undefined:
  - Port SerIn is absent; 0 is inserted as specified above.
- All other modes are unaffected either way.

Test Plan:
- Reset: Resetn=0 for 1 edge with Q previously 0xFF -> Q=0x00, Busy=0, Done=0, Ovf=0.
- Load: Mode=111, D=0xB4, Start for 1 cycle -> next cycle Q=0xB4, Done=1 for 1 cycle, Busy never asserted.
- Circular right: from Q=0xB4, Mode=001, Amount=3, Start -> Busy high 3 cycles; Q steps 0x5A, 0x2D, 0x96; Done pulse after the 3rd shift; Q=0x96.
- Arithmetic right: from Q=0x96, Mode=101, Amount=2 -> Q steps 0xCB, 0xE5; Done once; Ovf=0.
- Arithmetic left overflow: from Q=0x30, Mode=110, Amount=2 -> Q steps 0x60, 0xC0; Ovf=1 after the 2nd shift, held until the next Start, which clears it.
- Interference: Mode=100, Amount=5 from Q=0xFF; Start re-asserted with Mode=111 during Busy -> ignored. Resetn=0 at the 3rd shift edge -> Q=0x00, Busy=0, no Done pulse.
